// File: rtl/spm_bus_arbiter.sv
// N-master arbiter for the single-ported scratch-pad memory data port: per-cycle fixed or
// round-robin arbitration, bus lock, force mode and in-order read-return routing.
module spm_bus_arbiter #(
    parameter  int NUM_MASTERS = 3,
    parameter  int ADDR_WIDTH  = 30,
    parameter  int DATA_WIDTH  = 32,
    parameter  int MEM_LATENCY = 1,
    parameter  int RR_MODE     = 1,
    localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              force_en,
    input  logic [IDX_W-1:0]                  force_sel,
    input  logic [NUM_MASTERS-1:0]            req,
    input  logic [NUM_MASTERS-1:0]            lock,
    input  logic [NUM_MASTERS-1:0]            rw,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_MASTERS-1:0]            gnt,
    output logic [NUM_MASTERS-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              mem_as_,
    output logic                              mem_rw,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wr_data,
    input  logic [DATA_WIDTH-1:0]             mem_rd_data
);

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic vld;
        idx_t idx;
    } ret_t;

    idx_t                  rr_ptr_q, rr_ptr_d;
    logic                  lock_vld_q, lock_vld_d;
    idx_t                  lock_idx_q, lock_idx_d;
    logic                  force_q;
    ret_t                  pipe_q [MEM_LATENCY];
    ret_t                  pipe_d [MEM_LATENCY];
    logic [DATA_WIDTH-1:0] rd_hold_q, rd_hold_d;

    logic                   owner_req;
    logic                   any_vld, at_ptr_vld;
    idx_t                   any_idx, at_ptr_idx;
    logic                   win_vld, win_by_lock;
    idx_t                   win_idx;
    logic [NUM_MASTERS-1:0] win_oh;
    ret_t                   ret_out;

    // Winner selection; reset suppresses every grant in the cycle it is high.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        owner_req   = 1'b0;
        any_vld     = 1'b0;
        any_idx     = '0;
        at_ptr_vld  = 1'b0;
        at_ptr_idx  = '0;
        win_vld     = 1'b0;
        win_idx     = '0;
        win_by_lock = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (lock_vld_q && lock_idx_q == idx_t'(i) && req[i]) owner_req = 1'b1;
            if (req[i]) begin
                any_vld = 1'b1;
                any_idx = idx_t'(i);
            end
            if (req[i] && idx_t'(i) >= rr_ptr_q) begin
                at_ptr_vld = 1'b1;
                at_ptr_idx = idx_t'(i);
            end
        end
        if (!reset) begin
            if (force_en) begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (force_sel == idx_t'(i) && req[i]) begin
                        win_vld = 1'b1;
                        win_idx = idx_t'(i);
                    end
                end
            end else if (owner_req) begin
                win_vld     = 1'b1;
                win_idx     = lock_idx_q;
                win_by_lock = 1'b1;
            end else if (RR_MODE == 0 || !at_ptr_vld) begin
                win_vld = any_vld;
                win_idx = any_idx;
            end else begin
                win_vld = 1'b1;
                win_idx = at_ptr_idx;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            win_oh[i] = win_vld && win_idx == idx_t'(i);
        end
    end

    always_comb begin
        gnt         = win_oh;
        mem_as_     = ~win_vld;
        mem_rw      = 1'b1;
        mem_addr    = '0;
        mem_wr_data = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_oh[i]) begin
                mem_rw      = rw[i];
                mem_addr    = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wr_data = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Force mode freezes pointer and lock; a locked re-grant keeps the pointer where it is.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        if (force_en) begin
            if (!force_q) lock_vld_d = 1'b0;
        end else if (win_vld) begin
            if (!win_by_lock) begin
                rr_ptr_d = (win_idx == idx_t'(NUM_MASTERS - 1)) ? '0 : idx_t'(win_idx + 1'b1);
            end
            lock_vld_d = |(win_oh & lock);
            lock_idx_d = win_idx;
        end else begin
            lock_vld_d = 1'b0;
        end
    end

    always_comb begin
        pipe_d[0].vld = win_vld && |(win_oh & rw);
        pipe_d[0].idx = win_idx;
        for (int k = 1; k < MEM_LATENCY; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    assign ret_out = pipe_q[MEM_LATENCY-1];

    // Return data is passed straight through in the strobe cycle and held afterwards.
    always_comb begin
        rd_valid  = '0;
        rd_hold_d = ret_out.vld ? mem_rd_data : rd_hold_q;
        rd_data   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            rd_valid[i] = !reset && ret_out.vld && ret_out.idx == idx_t'(i);
        end
        if (!reset) rd_data = ret_out.vld ? mem_rd_data : rd_hold_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            rr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            force_q    <= 1'b0;
            rd_hold_q  <= '0;
            // NOTE: the return pipeline is reset on purpose; a stale valid bit would fake a read return.
            for (int k = 0; k < MEM_LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            force_q    <= force_en;
            rd_hold_q  <= rd_hold_d;
            for (int k = 0; k < MEM_LATENCY; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

endmodule

// File: tb/tb_spm_bus_arbiter.sv
// Directed bench for spm_bus_arbiter: three instances (RR lat 2, fixed lat 1, RR lat 3)
// share one stimulus bus; each scenario checks the instance it targets.
module tb_spm_bus_arbiter;

    localparam int NM = 3;
    localparam int AW = 30;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            force_en;
    logic [1:0]      force_sel;
    logic [NM-1:0]   req, lock, rw;
    logic [NM*AW-1:0] addr;
    logic [NM*DW-1:0] wr_data;
    logic [DW-1:0]   mem_rd_data;

    logic [NM-1:0] gnt_rr2, rdv_rr2, gnt_fp1, rdv_fp1, gnt_rr3, rdv_rr3;
    logic [DW-1:0] rdd_rr2, rdd_fp1, rdd_rr3, mwd_rr2, mwd_fp1, mwd_rr3;
    logic [AW-1:0] ma_rr2, ma_fp1, ma_rr3;
    logic          as_rr2, as_fp1, as_rr3, mrw_rr2, mrw_fp1, mrw_rr3;

    int n_tests = 0;
    int n_fail  = 0;

    spm_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(2), .RR_MODE(1)) u_rr2 (
        .clk(clk), .reset(reset), .force_en(force_en), .force_sel(force_sel), .req(req), .lock(lock),
        .rw(rw), .addr(addr), .wr_data(wr_data), .gnt(gnt_rr2), .rd_valid(rdv_rr2), .rd_data(rdd_rr2),
        .mem_as_(as_rr2), .mem_rw(mrw_rr2), .mem_addr(ma_rr2), .mem_wr_data(mwd_rr2), .mem_rd_data(mem_rd_data));

    spm_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1), .RR_MODE(0)) u_fp1 (
        .clk(clk), .reset(reset), .force_en(force_en), .force_sel(force_sel), .req(req), .lock(lock),
        .rw(rw), .addr(addr), .wr_data(wr_data), .gnt(gnt_fp1), .rd_valid(rdv_fp1), .rd_data(rdd_fp1),
        .mem_as_(as_fp1), .mem_rw(mrw_fp1), .mem_addr(ma_fp1), .mem_wr_data(mwd_fp1), .mem_rd_data(mem_rd_data));

    spm_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3), .RR_MODE(1)) u_rr3 (
        .clk(clk), .reset(reset), .force_en(force_en), .force_sel(force_sel), .req(req), .lock(lock),
        .rw(rw), .addr(addr), .wr_data(wr_data), .gnt(gnt_rr3), .rd_valid(rdv_rr3), .rd_data(rdd_rr3),
        .mem_as_(as_rr3), .mem_rw(mrw_rr3), .mem_addr(ma_rr3), .mem_wr_data(mwd_rr3), .mem_rd_data(mem_rd_data));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        lock     = '0;
        rw       = '0;
        force_en = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NM-1:0] rr_seq [6];
        int            rr_idx [6];
        rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rr_idx = '{0, 1, 2, 0, 1, 2};

        reset       = 1'b1;
        force_en    = 1'b0;
        force_sel   = '0;
        req         = 3'b111;
        lock        = '0;
        rw          = '0;
        addr        = '0;
        wr_data     = '0;
        mem_rd_data = '0;
        for (int i = 0; i < NM; i++) begin
            set_addr(i, 30'h100 + AW'(i));
            wr_data[i*DW +: DW] = 32'hA000_0000 + DW'(i);
        end

        // Reset holds every output at its idle value even with requests pending.
        next_cycle();
        sample();
        check("rst_gnt", gnt_rr2, 3'b000);
        check("rst_as", as_rr2, 1'b1);
        check("rst_rw", mrw_rr2, 1'b1);
        check("rst_addr", ma_rr2, 0);
        check("rst_wdata", mwd_rr2, 0);
        check("rst_rdv", rdv_rr2, 3'b000);
        check("rst_rdata", rdd_rr2, 0);
        next_cycle();
        reset = 1'b0;

        // Round-robin rotation with all masters requesting writes.
        for (int c = 0; c < 6; c++) begin
            sample();
            check($sformatf("rr_gnt_%0d", c), gnt_rr2, rr_seq[c]);
            check($sformatf("rr_addr_%0d", c), ma_rr2, 30'h100 + AW'(rr_idx[c]));
            check($sformatf("rr_wdata_%0d", c), mwd_rr2, 32'hA000_0000 + DW'(rr_idx[c]));
            check($sformatf("rr_as_%0d", c), as_rr2, 1'b0);
            check($sformatf("fp_gnt_%0d", c), gnt_fp1, 3'b001);
            next_cycle();
        end

        // Fixed priority: master 2 never wins while a lower index requests.
        do_reset();
        req = 3'b110;
        sample();
        check("fp_110", gnt_fp1, 3'b010);
        next_cycle();
        req = 3'b111;
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("fp_111_%0d", c), gnt_fp1, 3'b001);
            next_cycle();
        end

        // Read by master 1 with latency 2, then a write that must not return.
        do_reset();
        req = 3'b010;
        rw  = 3'b010;
        set_addr(1, 30'h10);
        sample();
        check("rd_gnt", gnt_rr2, 3'b010);
        check("rd_memrw", mrw_rr2, 1'b1);
        check("rd_addr", ma_rr2, 30'h10);
        next_cycle();
        req = '0;
        sample();
        check("rd_t1_rdv", rdv_rr2, 3'b000);
        check("rd_fp_t1_rdv", rdv_fp1, 3'b010);
        next_cycle();
        mem_rd_data = 32'hDEAD_BEEF;
        sample();
        check("rd_t2_rdv", rdv_rr2, 3'b010);
        check("rd_t2_data", rdd_rr2, 32'hDEAD_BEEF);
        next_cycle();
        mem_rd_data = 32'h1234_5678;
        sample();
        check("rd_t3_rdv", rdv_rr2, 3'b000);
        check("rd_t3_hold", rdd_rr2, 32'hDEAD_BEEF);
        next_cycle();
        req = 3'b010;
        rw  = 3'b000;
        sample();
        check("wr_memrw", mrw_rr2, 1'b0);
        next_cycle();
        req = '0;
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("wr_no_rdv_%0d", c), rdv_rr2, 3'b000);
            next_cycle();
        end

        // Master 2 locks the bus against higher-priority requests; the pointer wraps to 0.
        do_reset();
        req = 3'b010;
        next_cycle();
        req  = 3'b111;
        lock = 3'b100;
        for (int c = 0; c < 4; c++) begin
            sample();
            check($sformatf("lock_gnt_%0d", c), gnt_rr2, 3'b100);
            next_cycle();
        end
        req  = 3'b011;
        lock = 3'b000;
        sample();
        check("unlock_gnt", gnt_rr2, 3'b001);
        next_cycle();

        // Force mode grants only force_sel, and only while it requests.
        do_reset();
        force_en  = 1'b1;
        force_sel = 2'd2;
        req       = 3'b011;
        sample();
        check("force_nogrant", gnt_rr2, 3'b000);
        check("force_as", as_rr2, 1'b1);
        check("force_fp_nogrant", gnt_fp1, 3'b000);
        next_cycle();
        req = 3'b111;
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("force_gnt_%0d", c), gnt_rr2, 3'b100);
            next_cycle();
        end
        force_sel = 2'd3;
        sample();
        check("force_sel_oob", gnt_rr2, 3'b000);
        next_cycle();

        // Force entry drops the lock owner and leaves the pointer untouched.
        do_reset();
        req  = 3'b001;
        lock = 3'b001;
        next_cycle();
        force_en  = 1'b1;
        force_sel = 2'd1;
        req       = 3'b011;
        lock      = 3'b000;
        sample();
        check("force_entry_gnt", gnt_rr2, 3'b010);
        next_cycle();
        force_en = 1'b0;
        sample();
        check("force_exit_gnt", gnt_rr2, 3'b010);
        next_cycle();

        // Reset one cycle after a granted read discards the return (latency 3).
        do_reset();
        req = 3'b001;
        rw  = 3'b001;
        set_addr(0, 30'h20);
        sample();
        check("rst_rd_gnt", gnt_rr3, 3'b001);
        check("rst_rd_addr", ma_rr3, 30'h20);
        next_cycle();
        reset = 1'b1;
        sample();
        check("rst_mid_gnt", gnt_rr3, 3'b000);
        check("rst_mid_as", as_rr3, 1'b1);
        check("rst_mid_rw", mrw_rr3, 1'b1);
        check("rst_mid_addr", ma_rr3, 0);
        check("rst_mid_wdata", mwd_rr3, 0);
        next_cycle();
        reset       = 1'b0;
        req         = '0;
        rw          = '0;
        mem_rd_data = 32'hCAFE_F00D;
        for (int c = 0; c < 4; c++) begin
            sample();
            check($sformatf("rst_no_rdv_%0d", c), rdv_rr3, 3'b000);
            check($sformatf("rst_rdata_%0d", c), rdd_rr3, 0);
            next_cycle();
        end
        req = 3'b111;
        sample();
        check("rst_next_gnt", gnt_rr3, 3'b001);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spm_bus_arbiter.md
Name: spm_bus_arbiter

Overview:
- Parametrised N-master arbiter that shares the single-ported scratch-pad memory (SPM) data port between masters such as instruction fetch, the load/store unit and the test/debug port.
- Replaces the static cpu_en-controlled port mux with per-cycle arbitration, a grant handshake, bus lock for atomic sequences, and read-return routing over a configurable memory latency.
- Sits between the masters and the SPM mem_* port.

Parameters:
NUM_MASTERS, 3, number of requesting masters (2..8); index 0 is highest fixed priority.
ADDR_WIDTH, 30, word address width.
DATA_WIDTH, 32, data width.
MEM_LATENCY, 1, cycles from an accepted read to valid mem_rd_data (1..4).
RR_MODE, 1, 0 = fixed priority, 1 = round-robin.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
force_en  in  1  force mode: only master force_sel may be granted.
force_sel  in  clog2(NUM_MASTERS)  master selected in force mode.
req  in  NUM_MASTERS  per-master access request.
lock  in  NUM_MASTERS  per-master bus-lock request, qualified by req.
rw  in  NUM_MASTERS  per-master direction: 1 = read, 0 = write.
addr  in  NUM_MASTERS*ADDR_WIDTH  packed word addresses; master i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
wr_data  in  NUM_MASTERS*DATA_WIDTH  packed write data, same packing.
gnt  out  NUM_MASTERS  one-hot grant; the access is accepted in the same cycle.
rd_valid  out  NUM_MASTERS  one-hot read-return strobe.
rd_data  out  DATA_WIDTH  read data, shared by all masters, qualified by rd_valid.
mem_as_  out  1  SPM address strobe, active low.
mem_rw  out  1  SPM direction: 1 = read, 0 = write.
mem_addr  out  ADDR_WIDTH  SPM address.
mem_wr_data  out  DATA_WIDTH  SPM write data.
mem_rd_data  in  DATA_WIDTH  SPM read data, valid MEM_LATENCY cycles after the access.

Behaviour:
- Reset, and every cycle reset is high:
  - gnt = 0, rd_valid = 0, rd_data = 0.
  - mem_as_ = 1, mem_rw = 1, mem_addr = 0, mem_wr_data = 0.
  - RR pointer = 0, lock owner cleared, return pipeline flushed.
  - A reset mid-operation discards any outstanding read; no rd_valid is produced for it.
- Grant is combinational from the current req/lock/force inputs and the registered state.
  - At most one gnt bit is high per cycle.
  - When gnt[i] = 1, the arbiter drives mem_as_ = 0 and mem_rw/mem_addr/mem_wr_data from master i in that same cycle.
  - When no bit is granted, mem_as_ = 1 and the other mem_* outputs hold 0 / read.
- Winner selection, first matching rule applies:
  1. force_en = 1: grant force_sel if req[force_sel] = 1, otherwise grant nothing. Lock and the pointer are ignored and not updated. A force_sel value >= NUM_MASTERS grants nothing.
  2. Lock owner valid and req[owner] = 1: grant the owner.
  3. RR_MODE = 0: grant the lowest requesting index.
  4. RR_MODE = 1: grant the first requesting index at or after the RR pointer, searching upward and wrapping at NUM_MASTERS-1 -> 0.
- Registered updates on each grant to master w, when force_en = 0:
  - RR pointer <= (w == NUM_MASTERS-1) ? 0 : w+1.
  - Lock owner <= w if lock[w] = 1; otherwise cleared.
  - The lock owner is also cleared in any cycle where the owner's req = 0.
  - While lock is held, the RR pointer does not advance.
- Force entry: force_en rising clears the lock owner.
- Read return:
  - A MEM_LATENCY-deep shift register carries {valid, master index} for each granted read.
  - At the pipeline output: rd_valid[idx] = 1 and rd_data = mem_rd_data, registered into rd_data in the same cycle rd_valid rises.
  - rd_data holds its value when rd_valid = 0.
  - Writes produce no rd_valid.
  - Back-to-back reads are fully pipelined: one access per cycle, and returns arrive in order.
- Simultaneous events:
  - A new grant and a read return for a different master in the same cycle are independent.
  - req deasserted in the grant cycle cancels the access; no partial state is left.

Test Plan:
- RR_MODE = 1, req = 3'b111 held for 6 cycles -> gnt sequence 001, 010, 100, 001, 010, 100; mem_addr follows each granted master.
- RR_MODE = 0, req = 3'b110 then 3'b111 -> gnt = 010, then 001 while req[0] stays high; master 2 is never granted.
- Master 1 reads addr 0x10 with mem_rd_data = 0xDEADBEEF, MEM_LATENCY = 2 -> rd_valid = 3'b010 exactly 2 cycles after gnt, rd_data = 0xDEADBEEF; no rd_valid on a write to 0x10.
- Master 2 req + lock for 4 cycles while req = 3'b111 -> gnt = 100 for all 4 cycles; lock dropped -> next grant goes to master 0 (pointer at 0 after wrap).
- force_en = 1, force_sel = 2, req = 3'b011 -> gnt = 0 and mem_as_ = 1; raise req[2] -> gnt = 100 every cycle.
- Reset pulsed 1 cycle after a granted read with MEM_LATENCY = 3 -> no rd_valid ever appears, all outputs take their reset values, and the next grant starts from master 0.
